// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO, with MTHI/MTLO and PC stall.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall,
  output logic             done
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t r_state, w_next;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_p;
  logic [WIDTH-1:0]   r_op2, r_a, r_hi, r_lo;
  logic               r_div, r_neg_q, r_neg_r, r_bz, r_done;
  logic               w_sa, w_sb, w_ge;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_sub, w_quo, w_rem;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_mul, w_div, w_prod;
  assign w_sa    = op[0] & a[WIDTH-1];
  assign w_sb    = op[0] & b[WIDTH-1];
  assign w_abs_a = w_sa ? -a : a;
  assign w_abs_b = w_sb ? -b : b;
  // r_p holds {accumulator, multiplier} for multiply and {remainder, dividend/quotient} for divide
  assign w_sum  = {1'b0, r_p[2*WIDTH-1:WIDTH]} + {1'b0, r_p[0] ? r_op2 : '0};
  assign w_mul  = {w_sum, r_p[WIDTH-1:1]};
  assign w_ge   = r_p[2*WIDTH-1:WIDTH-1] >= {1'b0, r_op2};
  assign w_sub  = r_p[2*WIDTH-2:WIDTH-1] - r_op2;
  assign w_div  = w_ge ? {w_sub, r_p[WIDTH-2:0], 1'b1} : {r_p[2*WIDTH-2:0], 1'b0};
  assign w_prod = r_neg_q ? -r_p : r_p;
  assign w_quo  = r_neg_q ? -r_p[WIDTH-1:0] : r_p[WIDTH-1:0];
  assign w_rem  = r_neg_r ? -r_p[2*WIDTH-1:WIDTH] : r_p[2*WIDTH-1:WIDTH];
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE) ? (start ? RUN : IDLE) :
             (r_state == RUN)  ? ((r_cnt == CW'(WIDTH-1)) ? FIX : RUN) : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_p     <= '0;
      r_op2   <= '0;
      r_a     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_div   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_bz    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= (r_state == FIX);
      if (r_state == IDLE) begin
        if (start) begin
          r_div   <= op[1];
          r_neg_q <= w_sa ^ w_sb;
          r_neg_r <= w_sa;
          r_bz    <= (b == '0);
          r_a     <= a;
          r_op2   <= op[1] ? w_abs_b : w_abs_a;
          r_p     <= {{WIDTH{1'b0}}, op[1] ? w_abs_a : w_abs_b};
          r_cnt   <= '0;
        end else begin
          if (hi_we) r_hi <= wdata;
          if (lo_we) r_lo <= wdata;
        end
      end else if (r_state == RUN) begin
        r_p   <= r_div ? w_div : w_mul;
        r_cnt <= r_cnt + CW'(1);
      end else begin
        r_hi <= !r_div ? w_prod[2*WIDTH-1:WIDTH] : r_bz ? r_a : w_rem;
        r_lo <= !r_div ? w_prod[WIDTH-1:0] : r_bz ? '1 : w_quo;
      end
    end
  end
  assign hi    = r_hi;
  assign lo    = r_lo;
  assign busy  = (r_state != IDLE);
  assign stall = (start & (r_state == IDLE)) | busy;
  assign done  = r_done;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed and random checks of muldiv_sequencer against an arithmetic reference model.
module tb_muldiv_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0, wdata = '0;
  logic [31:0] hi, lo;
  logic        busy, stall, done;
  int          vecs = 0, errs = 0;
  bit          armed = 0;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .hi(hi), .lo(lo), .busy(busy), .stall(stall), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void calc(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                               output logic [31:0] h, output logic [31:0] l);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = o[0] ? longint'($signed(x)) : longint'({32'b0, x});
    sy = o[0] ? longint'($signed(y)) : longint'({32'b0, y});
    if (!o[1]) begin
      p = 64'(sx * sy);
      h = p[63:32];
      l = p[31:0];
    end else if (y == 32'd0) begin
      h = x;
      l = 32'hFFFF_FFFF;
    end else begin
      q = sx / sy;
      r = sx % sy;
      h = r[31:0];
      l = q[31:0];
    end
  endfunction

  // Model: an operation takes 33 edges after the issuing edge, then HI/LO update and done pulses.
  int          m_left;
  logic [31:0] m_hi, m_lo, m_rhi, m_rlo;
  logic        m_done;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left <= 0;
      m_hi   <= '0;
      m_lo   <= '0;
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_hi   <= m_rhi;
          m_lo   <= m_rlo;
          m_done <= 1'b1;
        end
      end else if (start) begin
        calc(op, a, b, m_rhi, m_rlo);
        m_left <= 33;
      end else begin
        if (hi_we) m_hi <= wdata;
        if (lo_we) m_lo <= wdata;
      end
    end
  end

  always @(negedge clk) if (armed) begin
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    chk("busy", {31'b0, busy}, {31'b0, m_left > 0});
    chk("stall", {31'b0, stall}, {31'b0, (start && m_left == 0) || m_left > 0});
    chk("done", {31'b0, done}, {31'b0, m_done});
  end

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int inj, output int nstall, output bit ok);
    @(posedge clk); #1;
    start = 1'b1; op = o; a = x; b = y;
    nstall = 0; ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (stall) nstall++;
      if (done) begin ok = 1; break; end
      @(posedge clk); #1;
      start = 1'b0; lo_we = 1'b0;
      if (i == inj) begin
        start = 1'b1; lo_we = 1'b1; wdata = 32'hCAFE_F00D;
        op = 2'b10; a = 32'd77; b = 32'd5;
      end
    end
    chk("done_seen", {31'b0, ok}, 32'd1);
    @(posedge clk); #1;
    start = 1'b0; lo_we = 1'b0;
    @(negedge clk);
    chk("done_one_cycle", {31'b0, done}, 32'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom % 16;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int  ns;
    bit  ok;
    @(posedge clk);
    armed = 1;
    @(negedge clk);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    run_op(2'b00, 32'hFFFF_FFFF, 32'h0000_0002, -1, ns, ok);
    chk("multu_hi", hi, 32'h0000_0001);
    chk("multu_lo", lo, 32'hFFFF_FFFE);
    chk("multu_stall_cycles", ns, 32'd34);
    run_op(2'b01, 32'hFFFF_FFFD, 32'h0000_0007, -1, ns, ok);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFEB);
    run_op(2'b11, 32'hFFFF_FFF9, 32'h0000_0002, -1, ns, ok);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    run_op(2'b10, 32'd100, 32'd7, -1, ns, ok);
    chk("divu_hi", hi, 32'd2);
    chk("divu_lo", lo, 32'd14);
    run_op(2'b10, 32'h1234_5678, 32'd0, -1, ns, ok);
    chk("div0_hi", hi, 32'h1234_5678);
    chk("div0_lo", lo, 32'hFFFF_FFFF);
    chk("div0_stall_cycles", ns, 32'd34);
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, -1, ns, ok);
    chk("divovf_hi", hi, 32'd0);
    chk("divovf_lo", lo, 32'h8000_0000);

    @(posedge clk); #1 hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1 hi_we = 1'b0;
    @(negedge clk);
    chk("mthi", hi, 32'hDEAD_BEEF);

    run_op(2'b00, 32'd5, 32'd6, 10, ns, ok);
    chk("inj_hi", hi, 32'd0);
    chk("inj_lo", lo, 32'd30);
    chk("inj_stall_cycles", ns, 32'd34);

    @(posedge clk); #1 start = 1'b1; op = 2'b01; a = 32'hFFFF_FFF0; b = 32'd3;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_stall", {31'b0, stall}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    run_op(2'b10, 32'd9, 32'd3, -1, ns, ok);
    chk("post_rst_hi", hi, 32'd0);
    chk("post_rst_lo", lo, 32'd3);

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      start = ($urandom % 10) == 0;
      op    = 2'($urandom);
      a     = pick();
      b     = pick();
      hi_we = ($urandom % 6) == 0;
      lo_we = ($urandom % 6) == 0;
      wdata = $urandom;
    end
    @(posedge clk); #1 start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
